// File: rtl/alu_mc.sv
// alu_mc: handshaked Hack-style ALU with registered result, carry flag and
// optional DW-cycle shift-add multiply. Ports: valid/ready request side
// (x_i, y_i, ctrl_i, mul_i), valid/ready result side (out_o, zr_o, ng_o, cy_o).
module alu_mc #(
  parameter int DW     = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] x_i,
  input  logic [DW-1:0] y_i,
  input  logic [5:0]    ctrl_i,
  input  logic          mul_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_o,
  output logic          zr_o,
  output logic          ng_o,
  output logic          cy_o
);

  localparam int CW = $clog2(DW);

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] xs_q, xs_d;
  logic [DW-1:0] ys_q, ys_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          no_q, no_d;
  logic [DW-1:0] out_q, out_d;
  logic          valid_q, valid_d;
  logic          zr_q, zr_d;
  logic          ng_q, ng_d;
  logic          cy_q, cy_d;

  logic          zx, nx, zy, ny, f, no;
  logic [DW-1:0] xz, yz, xp, yp;
  logic [DW:0]   sum;
  logic [DW-1:0] r, res;
  logic [DW-1:0] acc_step, mul_res;
  logic          do_mul, accept;

  assign {zx, nx, zy, ny, f, no} = ctrl_i;

  assign xz  = zx ? '0 : x_i;
  assign yz  = zy ? '0 : y_i;
  assign xp  = nx ? ~xz : xz;
  assign yp  = ny ? ~yz : yz;
  assign sum = {1'b0, xp} + {1'b0, yp};
  assign r   = f ? sum[DW-1:0] : (xp & yp);
  assign res = no ? ~r : r;

  assign do_mul = MUL_EN & mul_i;

  assign in_ready_o = rst_n_i
                    & (state_q == IDLE)
                    & (~valid_q | out_ready_i);
  assign accept = in_valid_i & in_ready_o;

  // xs shifts left and ys shifts right each MUL cycle, so the
  // current multiplier bit is always ys_q[0] with x' aligned in xs_q.
  assign acc_step = acc_q + (ys_q[0] ? xs_q : '0);
  assign mul_res  = no_q ? ~acc_step : acc_step;

  always_comb begin
    state_d = state_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    no_d    = no_q;
    out_d   = out_q;
    valid_d = valid_q;
    zr_d    = zr_q;
    ng_d    = ng_q;
    cy_d    = cy_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            do_mul: begin
              xs_d    = xp;
              ys_d    = yp;
              acc_d   = '0;
              no_d    = no;
              cnt_d   = CW'(DW - 1);
              valid_d = 1'b0;
              state_d = MUL;
            end
            default: begin
              out_d   = res;
              zr_d    = (res == '0);
              ng_d    = res[DW-1];
              cy_d    = f & sum[DW];
              valid_d = 1'b1;
            end
          endcase
        end else if (out_ready_i) begin
          valid_d = 1'b0;
        end
      end
      MUL: begin
        acc_d = acc_step;
        xs_d  = xs_q << 1;
        ys_d  = ys_q >> 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          out_d   = mul_res;
          zr_d    = (mul_res == '0);
          ng_d    = mul_res[DW-1];
          cy_d    = 1'b0;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      xs_q    <= '0;
      ys_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      no_q    <= 1'b0;
      out_q   <= '0;
      valid_q <= 1'b0;
      zr_q    <= 1'b0;
      ng_q    <= 1'b0;
      cy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      no_q    <= no_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      zr_q    <= zr_d;
      ng_q    <= ng_d;
      cy_q    <= cy_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_o       = out_q;
  assign zr_o        = zr_q;
  assign ng_o        = ng_q;
  assign cy_o        = cy_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: random and directed stimulus for alu_mc, checked every
// cycle against a transaction-level model of the ALU.
module tb_alu_mc;

  localparam int DW = 16;

  logic          clk_i;
  logic          rst_n_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [DW-1:0] x_i;
  logic [DW-1:0] y_i;
  logic [5:0]    ctrl_i;
  logic          mul_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] out_o;
  logic          zr_o;
  logic          ng_o;
  logic          cy_o;

  alu_mc #(.DW(DW), .MUL_EN(1'b1)) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .x_i        (x_i),
    .y_i        (y_i),
    .ctrl_i     (ctrl_i),
    .mul_i      (mul_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_o      (out_o),
    .zr_o       (zr_o),
    .ng_o       (ng_o),
    .cy_o       (cy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // model state
  int            m_busy;
  logic          m_valid;
  logic [DW-1:0] m_out;
  logic          m_cy;
  logic [DW-1:0] m_pend;
  logic          exp_rdy;
  logic          last_acc;
  logic [DW-1:0] obs[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pre(input logic [DW-1:0] v,
                                        input logic z, input logic n);
    logic [DW-1:0] t;
    t = z ? '0 : v;
    return n ? ~t : t;
  endfunction

  task automatic model_reset();
    m_busy  = 0;
    m_valid = 1'b0;
    m_out   = '0;
    m_cy    = 1'b0;
    m_pend  = '0;
  endtask

  task automatic model_edge(input logic acc);
    logic [DW-1:0] xp, yp, r;
    logic [31:0]   s;
    logic [31:0]   p;
    xp = pre(x_i, ctrl_i[5], ctrl_i[4]);
    yp = pre(y_i, ctrl_i[3], ctrl_i[2]);
    if (acc) begin
      if (mul_i) begin
        p      = 32'(xp) * 32'(yp);
        m_pend = ctrl_i[0] ? ~p[DW-1:0] : p[DW-1:0];
        m_busy = DW;
        m_valid = 1'b0;
      end else begin
        s = 32'(xp) + 32'(yp);
        r = ctrl_i[1] ? s[DW-1:0] : (xp & yp);
        m_out   = ctrl_i[0] ? ~r : r;
        m_cy    = ctrl_i[1] & s[DW];
        m_valid = 1'b1;
      end
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_out   = m_pend;
        m_cy    = 1'b0;
        m_valid = 1'b1;
      end
    end else if (m_valid && out_ready_i) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_all();
    exp_rdy = rst_n_i && (m_busy == 0) && (!m_valid || out_ready_i);
    chk("in_ready", 32'(in_ready_o), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid_o), 32'(m_valid));
    if (m_valid) begin
      chk("out", 32'(out_o), 32'(m_out));
      chk("zr", 32'(zr_o), 32'(m_out == '0));
      chk("ng", 32'(ng_o), 32'(m_out[DW-1]));
      chk("cy", 32'(cy_o), 32'(m_cy));
    end
    if (out_valid_o && out_ready_i) obs.push_back(out_o);
  endtask

  task automatic step(input logic v, input logic [DW-1:0] x,
                      input logic [DW-1:0] y, input logic [5:0] c,
                      input logic m, input logic ordy);
    @(negedge clk_i);
    in_valid_i  = v;
    x_i         = x;
    y_i         = y;
    ctrl_i      = c;
    mul_i       = m;
    out_ready_i = ordy;
    #1;
    check_all();
    @(posedge clk_i);
    last_acc = v & exp_rdy;
    model_edge(last_acc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, 1'b1);
  endtask

  task automatic check_lit(input string name, input logic [DW-1:0] o,
                           input logic zr, input logic ng,
                           input logic cy);
    #2;
    chk({name, "_valid"}, 32'(out_valid_o), 32'd1);
    chk({name, "_out"}, 32'(out_o), 32'(o));
    chk({name, "_zr"}, 32'(zr_o), 32'(zr));
    chk({name, "_ng"}, 32'(ng_o), 32'(ng));
    chk({name, "_cy"}, 32'(cy_o), 32'(cy));
  endtask

  task automatic check_zero(input string name);
    chk({name, "_valid"}, 32'(out_valid_o), 32'd0);
    chk({name, "_rdy"}, 32'(in_ready_o), 32'd0);
    chk({name, "_out"}, 32'(out_o), 32'd0);
    chk({name, "_flags"}, {29'd0, zr_o, ng_o, cy_o}, 32'd0);
  endtask

  logic [DW-1:0] rx[3];
  logic [DW-1:0] ry[3];
  logic [5:0]    rc[3];
  logic [DW-1:0] rexp[3];

  initial begin
    rst_n_i     = 1'b0;
    in_valid_i  = 1'b0;
    x_i         = '0;
    y_i         = '0;
    ctrl_i      = '0;
    mul_i       = 1'b0;
    out_ready_i = 1'b1;
    last_acc    = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    check_zero("reset");
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // 1: x+y
    step(1'b1, 16'd5, 16'd3, 6'b000010, 1'b0, 1'b1);
    check_lit("t1", 16'd8, 1'b0, 1'b0, 1'b0);
    // 2: x-y
    step(1'b1, 16'd3, 16'd5, 6'b010011, 1'b0, 1'b1);
    check_lit("t2a", 16'hFFFE, 1'b0, 1'b1, 1'b1);
    step(1'b1, 16'h1234, 16'h1234, 6'b010011, 1'b0, 1'b1);
    check_lit("t2b", 16'h0000, 1'b1, 1'b0, 1'b0);
    // 3: wrap-around carry
    step(1'b1, 16'hFFFF, 16'h0001, 6'b000010, 1'b0, 1'b1);
    check_lit("t3", 16'h0000, 1'b1, 1'b0, 1'b1);
    // 4: multiply
    step(1'b1, 16'd7, 16'd6, 6'b000010, 1'b1, 1'b1);
    idle(DW);
    check_lit("t4a", 16'd42, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'hFFFF, 16'd2, 6'b000010, 1'b1, 1'b1);
    idle(DW);
    check_lit("t4b", 16'hFFFE, 1'b0, 1'b1, 1'b0);

    // 5: backpressure over three requests
    idle(1);
    obs.delete();
    rx = '{16'd1, 16'd10, 16'd5};
    ry = '{16'd2, 16'd12, 16'd3};
    rc = '{6'b000010, 6'b000000, 6'b000011};
    rexp = '{16'd3, 16'd8, 16'hFFF7};
    begin
      int idx;
      int cyc;
      idx = 0;
      cyc = 0;
      while ((obs.size() < 3) && (cyc < 40)) begin
        if (idx < 3)
          step(1'b1, rx[idx], ry[idx], rc[idx], 1'b0, cyc >= 4);
        else
          step(1'b0, '0, '0, '0, 1'b0, 1'b1);
        if (last_acc) idx++;
        cyc++;
      end
      chk("t5_count", 32'(obs.size()), 32'd3);
      for (int i = 0; i < 3; i++)
        if (i < obs.size()) chk("t5_order", 32'(obs[i]), 32'(rexp[i]));
    end

    // 6: reset in the middle of a multiply
    step(1'b1, 16'd9, 16'd9, 6'b000010, 1'b1, 1'b1);
    idle(7);
    @(negedge clk_i);
    #2;
    rst_n_i = 1'b0;
    #1;
    check_zero("t6_rst");
    model_reset();
    @(posedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    step(1'b1, 16'd20, 16'd22, 6'b000010, 1'b0, 1'b1);
    check_lit("t6_after", 16'd42, 1'b0, 1'b0, 1'b0);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] c;
      c = 6'($urandom);
      step($urandom_range(0, 9) < 7, 16'($urandom), 16'($urandom), c,
           $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
    end
    idle(DW + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
